// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, sticky overflow/underflow flags and optional first-word-fall-through.
module sync_fifo_prog #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int ADDR  = 6,
  parameter int FWFT  = 0
) (
  input  logic             clka,
  input  logic             rsta,
  input  logic             ena,
  input  logic             wra,
  input  logic [WIDTH-1:0] dina,
  input  logic             enb,
  output logic [WIDTH-1:0] doutb,
  output logic             valid_b,
  input  logic [ADDR:0]    af_thresh,
  input  logic [ADDR:0]    ae_thresh,
  output logic [ADDR:0]    count,
  output logic             full,
  output logic             almost_full,
  output logic             empty,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR-1:0]  wp_r;
  logic [ADDR-1:0]  rp_r;
  logic [ADDR:0]    count_r;
  logic [ADDR:0]    count_nxt_s;
  logic             ovf_r;
  logic             unf_r;
  logic             ovf_nxt_s;
  logic             unf_nxt_s;
  logic             wr_req_s;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             full_s;
  logic             empty_s;

  // Status flags decoded from the registered count; thresholds are used live.
  always_comb begin
    full_s       = (count_r == DEPTH_C);
    empty_s      = (count_r == {(ADDR+1){1'b0}});
    almost_full  = (count_r >= af_thresh);
    almost_empty = (count_r <= ae_thresh);
  end

  assign full      = full_s;
  assign empty     = empty_s;
  assign count     = count_r;
  assign overflow  = ovf_r;
  assign underflow = unf_r;

  // Acceptance from start-of-cycle flags: a read never makes room for a same-cycle write.
  always_comb begin
    wr_req_s = ena & wra;
    wr_acc_s = wr_req_s & ~full_s;
    rd_acc_s = enb & ~empty_s;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + {{ADDR{1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{ADDR{1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
  end

  // Sticky error flags: a new error event takes priority over clr_err.
  always_comb begin
    ovf_nxt_s = ovf_r;
    unf_nxt_s = unf_r;
    if (wr_req_s && !wr_acc_s) begin
      ovf_nxt_s = 1'b1;
    end else if (clr_err) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
    if (enb && !rd_acc_s) begin
      unf_nxt_s = 1'b1;
    end else if (clr_err) begin
      unf_nxt_s = 1'b0;
    end else begin
      unf_nxt_s = unf_r;
    end
  end

  // Pointers, occupancy and error state.
  always_ff @(posedge clka) begin
    if (!rsta) begin
      wp_r    <= {ADDR{1'b0}};
      rp_r    <= {ADDR{1'b0}};
      count_r <= {(ADDR+1){1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      if (wr_acc_s) wp_r <= wp_r + {{(ADDR-1){1'b0}}, 1'b1};
      if (rd_acc_s) rp_r <= rp_r + {{(ADDR-1){1'b0}}, 1'b1};
      count_r <= count_nxt_s;
      ovf_r   <= ovf_nxt_s;
      unf_r   <= unf_nxt_s;
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clka) begin
    if (rsta && wr_acc_s) begin
      mem_r[wp_r] <= dina;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue is always presented; enb pops it.
      assign doutb   = mem_r[rp_r];
      assign valid_b = ~empty_s;
    end else begin : g_std
      logic [WIDTH-1:0] dout_r;
      logic             valid_r;

      // Registered read port: data and a one-cycle valid pulse per accepted read.
      always_ff @(posedge clka) begin
        if (!rsta) begin
          dout_r  <= {WIDTH{1'b0}};
          valid_r <= 1'b0;
        end else begin
          valid_r <= rd_acc_s;
          if (rd_acc_s) dout_r <= mem_r[rp_r];
        end
      end

      assign doutb   = dout_r;
      assign valid_b = valid_r;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench: one standard-read and one FWFT instance share all stimulus and
// are checked against a queue-based reference model.
module tb_sync_fifo_prog;
  localparam int W = 8;
  localparam int D = 64;
  localparam int A = 6;

  logic clk = 1'b0;
  logic rsta = 1'b0, ena = 1'b0, wra = 1'b0, enb = 1'b0, clr_err = 1'b0;
  logic [W-1:0] dina = '0;
  logic [A:0] af_thresh = 7'd48, ae_thresh = 7'd8;

  logic [W-1:0] doutb0, doutb1;
  logic [A:0] count0, count1;
  logic valid_b0, full0, af0, empty0, ae0, ovf0, unf0;
  logic valid_b1, full1, af1, empty1, ae1, ovf1, unf1;

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] q[$];
  logic [W-1:0] exp0[$];
  logic [W-1:0] exp1[$];
  bit m_ovf = 1'b0, m_unf = 1'b0, m_vb0 = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.WIDTH(W), .DEPTH(D), .ADDR(A), .FWFT(0)) dut0 (
    .clka(clk), .rsta(rsta), .ena(ena), .wra(wra), .dina(dina), .enb(enb),
    .doutb(doutb0), .valid_b(valid_b0), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .count(count0), .full(full0), .almost_full(af0), .empty(empty0), .almost_empty(ae0),
    .overflow(ovf0), .underflow(unf0), .clr_err(clr_err));

  sync_fifo_prog #(.WIDTH(W), .DEPTH(D), .ADDR(A), .FWFT(1)) dut1 (
    .clka(clk), .rsta(rsta), .ena(ena), .wra(wra), .dina(dina), .enb(enb),
    .doutb(doutb1), .valid_b(valid_b1), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .count(count1), .full(full1), .almost_full(af1), .empty(empty1), .almost_empty(ae1),
    .overflow(ovf1), .underflow(unf1), .clr_err(clr_err));

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict acceptance, advance the model at the edge.
  task automatic step(input bit e_a, input bit w_a, input logic [W-1:0] d,
                      input bit e_b, input bit clr, input bit rst_n);
    bit wr_req, wr_ok, rd_ok;
    rsta = rst_n; ena = e_a; wra = w_a; dina = d; enb = e_b; clr_err = clr;
    wr_req = e_a & w_a;
    wr_ok  = wr_req && (q.size() < D);
    rd_ok  = e_b && (q.size() > 0);
    if (rst_n && rd_ok) begin
      exp0.push_back(q[0]);
      exp1.push_back(q[0]);
    end
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); exp0.delete(); exp1.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_vb0 = 1'b0;
    end else begin
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(d);
      if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (wr_req && !wr_ok) m_ovf = 1'b1;
      if (e_b && !rd_ok) m_unf = 1'b1;
      m_vb0 = rd_ok;
    end
    #1;
  endtask

  // Monitor: status against the model every cycle, data popped from the scoreboard queues.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count0", int'(count0), q.size());
      chk("count1", int'(count1), q.size());
      chk("full0", full0, q.size() == D);
      chk("empty0", empty0, q.size() == 0);
      chk("af0", af0, q.size() >= int'(af_thresh));
      chk("ae0", ae0, q.size() <= int'(ae_thresh));
      chk("af1", af1, q.size() >= int'(af_thresh));
      chk("ovf0", ovf0, m_ovf);
      chk("unf1", unf1, m_unf);
      chk("valid_b0", valid_b0, m_vb0);
      chk("valid_b1", valid_b1, q.size() != 0);
      if (valid_b0) begin
        if (exp0.size() == 0) chk("std_unexpected_word", 1, 0);
        else chk("std_data", doutb0, exp0.pop_front());
      end
      if (rsta && valid_b1 && enb) begin
        if (exp1.size() == 0) chk("fwft_unexpected_pop", 1, 0);
        else chk("fwft_data", doutb1, exp1.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wrote;
    int cyc;
    @(posedge clk); #1;
    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_doutb0", doutb0, 0);
    chk("rst_count", count0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_af", af0, 0);

    // fill 0x00..0x3F
    for (int i = 0; i < D; i++) begin
      step(1, 1, W'(i), 0, 0, 1);
      if (i == D - 2) chk("full_early", full0, 0);
    end
    chk("fill_count", count0, 64);
    chk("fill_full", full0, 1);

    // overflow at full: read wins, write rejected
    step(1, 1, 8'hEE, 1, 0, 1);
    chk("ovf_count", count0, 63);
    chk("ovf_flag", ovf0, 1);
    chk("ovf_pop_word", doutb0, 8'h00);
    step(0, 0, 8'h00, 0, 1, 1);
    chk("ovf_clr", ovf0, 0);

    // drain, checking threshold edges
    for (int i = 0; i < D - 1; i++) begin
      step(0, 0, 8'h00, 1, 0, 1);
      if (q.size() == 47) chk("af_drop_47", af0, 0);
      if (q.size() == 9)  chk("ae_low_9", ae0, 0);
      if (q.size() == 8)  chk("ae_high_8", ae0, 1);
    end
    chk("drain_empty", empty0, 1);

    // underflow at empty: write wins, read rejected
    step(1, 1, 8'h3C, 1, 0, 1);
    chk("unf_count", count0, 1);
    chk("unf_flag", unf0, 1);
    chk("unf_valid", valid_b0, 0);
    step(0, 0, 8'h00, 1, 1, 1);
    step(0, 0, 8'h00, 0, 0, 1);

    // FWFT fall-through of a single word
    step(1, 1, 8'hA5, 0, 0, 1);
    chk("fwft_a5_data", doutb1, 8'hA5);
    chk("fwft_a5_valid", valid_b1, 1);
    step(0, 0, 8'h00, 0, 0, 1);
    chk("fwft_a5_hold", doutb1, 8'hA5);

    // random stream across pointer wrap, with occasional threshold extremes
    wrote = 0;
    cyc = 0;
    while (wrote < 200 && cyc < 3000) begin
      bit e_a, e_b;
      e_a = ($urandom_range(0, 99) < 55);
      e_b = ($urandom_range(0, 99) < 50);
      if (cyc % 60 == 0) begin
        af_thresh = (cyc % 120 == 0) ? 7'd0 : 7'($urandom_range(0, 64));
        ae_thresh = (cyc % 120 == 0) ? 7'd100 : 7'($urandom_range(0, 64));
      end
      if (e_a && q.size() < D) wrote++;
      step(e_a, 1, W'($urandom), e_b, ($urandom_range(0, 15) == 0), 1);
      cyc++;
    end
    chk("stream_done", wrote >= 200, 1);
    af_thresh = 7'd48;
    ae_thresh = 7'd8;

    // reset mid-operation with a coincident write
    step(0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 30; i++) step(1, 1, W'(i + 100), 0, 0, 1);
    chk("pre_rst_count", count0, 30);
    step(1, 1, 8'h77, 0, 0, 0);
    chk("mid_rst_count", count0, 0);
    chk("mid_rst_empty", empty0, 1);
    chk("mid_rst_ae", ae0, 1);
    chk("mid_rst_af", af0, 0);
    chk("mid_rst_full", full0, 0);
    chk("mid_rst_ovf", ovf0, 0);
    chk("mid_rst_unf", unf0, 0);
    chk("mid_rst_valid", valid_b0, 0);
    chk("mid_rst_doutb0", doutb0, 0);
    chk("mid_rst_valid1", valid_b1, 0);
    step(0, 0, 8'h00, 0, 0, 1);
    chk("rst_write_discarded", count1, 0);

    step(0, 0, 8'h00, 0, 0, 1);
    chk("exp0_drained", exp0.size(), 0);
    chk("exp1_drained", exp1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Single-clock, parametrised FIFO with runtime-programmable almost-full/almost-empty thresholds, a live occupancy count, sticky overflow/underflow error flags, and a selectable first-word-fall-through read mode. It is the single-domain successor to the dual-clock FIFO. It serves as the rate-matching buffer between producers and consumers that share one clock, keeping the same ena/wra/dina write and enb/doutb read port style.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 64, number of entries; power of two, ≥4
- ADDR, 6, pointer width; must equal log2(DEPTH)
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through

- clka  in  1  sole clock; all logic on rising edge
- rsta  in  1  synchronous, active-low reset (sampled at clka rising edge)
- ena  in  1  write-side enable
- wra  in  1  write strobe; a write is requested when ena & wra
- dina  in  WIDTH  write data
- enb  in  1  read request / pop
- doutb  out  WIDTH  read data
- valid_b  out  1  doutb holds a valid word (meaning per mode, see Operation)
- af_thresh  in  ADDR+1  almost-full threshold
- ae_thresh  in  ADDR+1  almost-empty threshold
- count  out  ADDR+1  current occupancy, 0..DEPTH
- full, almost_full, empty, almost_empty  out  1 each  status flags
- overflow, underflow  out  1 each  sticky error flags
- clr_err  in  1  clears overflow/underflow

## Operation
- Storage: DEPTH×WIDTH array, write pointer wp and read pointer rp, each ADDR bits, wrapping naturally DEPTH-1 → 0. Array contents are not cleared by reset.
- Write accept: ena & wra & !full. Data goes to mem[wp] and wp increments.
- Read accept: enb & !empty. rp increments.
- Acceptance uses the flags at the start of the cycle. A read does not free space for a same-cycle write.
- At full with a simultaneous write and read: the read is accepted, the write is rejected, and overflow is set.
- At empty with a simultaneous write and read: the write is accepted, the read is rejected, and underflow is set.
- count update: +1 for write only, −1 for read only, unchanged for both or neither.
- Flags are combinational decodes of the count register:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count ≥ af_thresh)
  - almost_empty = (count ≤ ae_thresh)
- Thresholds are sampled live; there is no qualification of threshold values. af_thresh = 0 forces almost_full high. ae_thresh ≥ DEPTH forces almost_empty high.
- Errors: a rejected write request sets overflow; a rejected read request sets underflow. Both stay set until clr_err or reset.
  - If clr_err coincides with a new error event, the flag ends the cycle set (set wins).
- FWFT = 0: on read accept, doutb ← mem[rp] at that edge and valid_b = 1 for the following cycle. Otherwise valid_b = 0 and doutb holds its last value.
- FWFT = 1: doutb = mem[rp] combinationally and valid_b = !empty. enb acts as a pop of the presented word.

## Timing
- Reset: when rsta = 0 at an edge, the following hold after that edge. Reset overrides any same-cycle read or write.
  - wp = rp = 0 and count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = (af_thresh == 0).
  - overflow = underflow = 0.
  - doutb = 0 for FWFT = 0. For FWFT = 1, doutb is don't-care while valid_b = 0.
  - valid_b = 0.
- Reset mid-operation discards all stored words.
- Write at edge N: count, empty, full and the almost flags reflect the write after edge N.
- FWFT = 1 latency:
  - A word written into an empty FIFO at edge N appears on doutb with valid_b = 1 after edge N.
  - Pop at edge M: the next word, or valid_b = 0, appears after edge M.
- FWFT = 0 latency: read accepted at edge M puts data on doutb after edge M. Minimum write-to-data latency is 2 edges.
- Sustained simultaneous read and write at 0 < count < DEPTH yields one word per cycle with count constant.

## Test plan
- Fill/drain, DEPTH = 64, FWFT = 0:
  - Write 0x00..0x3F on 64 consecutive cycles: full rises after the 64th edge and count = 64.
  - Read 64 cycles: doutb returns 0x00..0x3F in order, one per valid_b pulse, and empty = 1 at the end.
- Overflow: at full, assert ena = wra = enb = 1 for one cycle.
  - Required: count = 63, overflow = 1, and the oldest word is popped.
  - Then clr_err = 1 for one cycle: overflow = 0.
- Underflow: at empty, assert enb = 1 with ena & wra = 1 for one cycle.
  - Required: count = 1, underflow = 1, valid_b = 0.
- Thresholds: af_thresh = 48, ae_thresh = 8.
  - almost_full asserts exactly when count reaches 48 and drops when count reaches 47.
  - almost_empty is 1 for count ≤ 8 and 0 at count = 9.
- FWFT = 1, wrap-around:
  - Write 0xA5 into an empty FIFO: doutb = 0xA5 and valid_b = 1 the next cycle without enb.
  - Then stream 200 words with random ena/enb: the output order matches the input order across pointer wrap.
- Reset mid-operation: at count = 30, drive rsta = 0 for one edge together with a write. Required: count = 0, empty = 1, all flags at reset values, and the write is discarded.
